// File: rtl/slave_port_arbiter_pkg.sv
// Shared types and constants for the per-slave crossbar port arbiter.
package slave_port_arbiter_pkg;

  localparam int unsigned N_MASTERS = 4;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned SEL_HI    = 31;
  localparam int unsigned SEL_LO    = 30;
  localparam int unsigned SEL_W     = SEL_HI - SEL_LO + 1;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RDATA = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              cmd;
    logic [DATA_W-1:0] wdata;
  } slv_req_t;

endpackage

// File: rtl/slave_port_arbiter_rr_pick.sv
// Rotating-priority pick: first set bit of eligible at or after ptr, wrapping.
module rr_pick
  import slave_port_arbiter_pkg::*;
(
  input  logic [N_MASTERS-1:0] eligible,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     index,
  output logic                 any
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest eligible index wins.
  always_comb begin
    index = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (eligible[cand]) begin
        index = cand;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/slave_port_arbiter.sv
// One slave port of a 4x4 crossbar: round-robin arbitration among masters
// addressing this slave, with a one-cycle read-data return phase.
module slave_port_arbiter
  import slave_port_arbiter_pkg::*;
#(
  parameter logic [SEL_W-1:0] SLAVE_ID  = 2'b00,
  parameter int unsigned      N_MASTERS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS-1:0]          m_cmd,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
  output logic                          s_req,
  output logic [ADDR_W-1:0]             s_addr,
  output logic                          s_cmd,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_ack,
  input  logic [DATA_W-1:0]             s_rdata
);

  state_e               state;
  logic [IDX_W-1:0]     g;
  logic [IDX_W-1:0]     ptr;
  logic [N_MASTERS-1:0] elig;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 g_elig;
  slv_req_t             g_bus;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_elig_lane
    assign elig[i] = m_req[i] && (m_addr[i*ADDR_W+SEL_LO +: SEL_W] == SLAVE_ID);
  end

  rr_pick u_rr_pick (
    .eligible (elig),
    .ptr      (ptr),
    .index    (pick_idx),
    .any      (pick_any)
  );

  // Request fields of the granted master.
  always_comb begin
    g_bus.addr  = m_addr[32'(g)*ADDR_W +: ADDR_W];
    g_bus.cmd   = m_cmd[g];
    g_bus.wdata = m_wdata[32'(g)*DATA_W +: DATA_W];
    g_elig      = elig[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      g     <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            g     <= pick_idx;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A master that withdraws before the ack forfeits without moving ptr.
          if (!g_elig) begin
            state <= ST_IDLE;
          end else if (s_ack) begin
            ptr   <= g + IDX_W'(1);
            state <= (g_bus.cmd == CMD_WRITE) ? ST_IDLE : ST_RDATA;
          end
        end
        ST_RDATA: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_req   = 1'b0;
    s_addr  = '0;
    s_cmd   = 1'b0;
    s_wdata = '0;
    m_ack   = '0;
    m_rdata = '0;
    if (state == ST_GRANT) begin
      s_req    = g_elig;
      s_addr   = g_bus.addr;
      s_cmd    = g_bus.cmd;
      s_wdata  = g_bus.wdata;
      m_ack[g] = s_ack && g_elig;
    end
    if (state == ST_RDATA) begin
      m_rdata[32'(g)*DATA_W +: DATA_W] = s_rdata;
    end
  end

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Self-checking bench: directed vector table, hand sequences, random vs model.
module tb_slave_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   m_req, m_cmd;
  logic [127:0] m_addr, m_wdata;
  logic         s_ack0, s_ack2;
  logic [31:0]  s_rdata;
  logic [3:0]   m_ack0, m_ack2;
  logic [127:0] m_rdata0, m_rdata2;
  logic         s_req0, s_req2, s_cmd0, s_cmd2;
  logic [31:0]  s_addr0, s_addr2, s_wdata0, s_wdata2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slave_port_arbiter #(.SLAVE_ID(2'b00), .N_MASTERS(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd),
    .m_wdata(m_wdata), .m_ack(m_ack0), .m_rdata(m_rdata0), .s_req(s_req0),
    .s_addr(s_addr0), .s_cmd(s_cmd0), .s_wdata(s_wdata0), .s_ack(s_ack0),
    .s_rdata(s_rdata)
  );

  slave_port_arbiter #(.SLAVE_ID(2'b10), .N_MASTERS(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd),
    .m_wdata(m_wdata), .m_ack(m_ack2), .m_rdata(m_rdata2), .s_req(s_req2),
    .s_addr(s_addr2), .s_cmd(s_cmd2), .s_wdata(s_wdata2), .s_ack(s_ack2),
    .s_rdata(s_rdata)
  );

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  // owner: master holding the slave (-1 none); rd_lane: master due read data.
  int         owner[2];
  int         rd_lane[2];
  int         prio[2];
  logic [1:0] sid[2];

  function automatic logic [31:0] lane(logic [127:0] v, int i);
    return v[i*32 +: 32];
  endfunction

  function automatic bit elig(int k, int i);
    return m_req[i] && ((lane(m_addr, i) >> 30) == {30'b0, sid[k]});
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1; rd_lane[k] = -1; prio[k] = 0;
    end
  endtask

  task automatic model_check(int k);
    logic e_req, e_cmd, a_req, a_cmd, ack;
    logic [31:0] e_addr, e_wdata, a_addr, a_wdata;
    logic [3:0] e_ack, a_ack;
    logic [127:0] e_rd, a_rd;
    if (k == 0) begin
      a_req = s_req0; a_addr = s_addr0; a_cmd = s_cmd0; a_wdata = s_wdata0;
      a_ack = m_ack0; a_rd = m_rdata0; ack = s_ack0;
    end else begin
      a_req = s_req2; a_addr = s_addr2; a_cmd = s_cmd2; a_wdata = s_wdata2;
      a_ack = m_ack2; a_rd = m_rdata2; ack = s_ack2;
    end
    e_req = 0; e_cmd = 0; e_addr = 0; e_wdata = 0; e_ack = 0; e_rd = 0;
    if (owner[k] >= 0) begin
      e_req   = elig(k, owner[k]);
      e_addr  = lane(m_addr, owner[k]);
      e_wdata = lane(m_wdata, owner[k]);
      e_cmd   = m_cmd[owner[k]];
      if (e_req && ack) e_ack[owner[k]] = 1'b1;
    end
    if (rd_lane[k] >= 0) e_rd[rd_lane[k]*32 +: 32] = s_rdata;
    chk($sformatf("rnd%0d_s_req", k),   a_req,   e_req);
    chk($sformatf("rnd%0d_s_addr", k),  a_addr,  e_addr);
    chk($sformatf("rnd%0d_s_cmd", k),   a_cmd,   e_cmd);
    chk($sformatf("rnd%0d_s_wdata", k), a_wdata, e_wdata);
    chk($sformatf("rnd%0d_m_ack", k),   a_ack,   e_ack);
    chk($sformatf("rnd%0d_m_rdata", k), a_rd,    e_rd);
  endtask

  task automatic model_step(int k);
    logic ack;
    int o;
    bit found;
    ack = (k == 0) ? s_ack0 : s_ack2;
    if (rd_lane[k] >= 0) begin
      rd_lane[k] = -1;
    end else if (owner[k] >= 0) begin
      o = owner[k];
      if (!elig(k, o)) begin
        owner[k] = -1;
      end else if (ack) begin
        prio[k]  = (o + 1) % 4;
        owner[k] = -1;
        if (m_cmd[o] == 1'b0) rd_lane[k] = o;
      end
    end else begin
      found = 0;
      for (int off = 0; off < 4; off++) begin
        if (!found && elig(k, (prio[k] + off) % 4)) begin
          owner[k] = (prio[k] + off) % 4;
          found = 1;
        end
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]   req;
    logic         ack;
    logic [31:0]  rdata;
    logic         e_sreq;
    logic [31:0]  e_saddr;
    logic         e_scmd;
    logic [31:0]  e_swdata;
    logic [3:0]   e_mack;
    logic [127:0] e_mrdata;
  } vec_t;

  function automatic vec_t mk(logic [3:0] req, logic ack, logic [31:0] rdata,
                              logic sreq, logic [31:0] saddr, logic scmd,
                              logic [31:0] swdata, logic [3:0] mack, logic [127:0] mrdata);
    vec_t v;
    v.req = req; v.ack = ack; v.rdata = rdata; v.e_sreq = sreq; v.e_saddr = saddr;
    v.e_scmd = scmd; v.e_swdata = swdata; v.e_mack = mack; v.e_mrdata = mrdata;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_s_req0"},   s_req0,   0);
    chk({tag, "_s_addr0"},  s_addr0,  0);
    chk({tag, "_s_cmd0"},   s_cmd0,   0);
    chk({tag, "_s_wdata0"}, s_wdata0, 0);
    chk({tag, "_m_ack0"},   m_ack0,   0);
    chk({tag, "_m_rdata0"}, m_rdata0, 0);
    chk({tag, "_s_req2"},   s_req2,   0);
    chk({tag, "_m_ack2"},   m_ack2,   0);
  endtask

  vec_t vt[14];
  int   order[$];
  int   n_m2;

  initial begin
    sid[0] = 2'b00; sid[1] = 2'b10;
    vt[0]  = mk(4'b0010, 0, 32'h0,        0, 32'h0,  0, 32'h0,        4'b0000, 128'h0);
    vt[1]  = mk(4'b0010, 0, 32'h0,        1, 32'h10, 1, 32'hDEADBEEF, 4'b0000, 128'h0);
    vt[2]  = mk(4'b0010, 1, 32'h0,        1, 32'h10, 1, 32'hDEADBEEF, 4'b0010, 128'h0);
    vt[3]  = mk(4'b0000, 0, 32'h0,        0, 32'h0,  0, 32'h0,        4'b0000, 128'h0);
    vt[4]  = mk(4'b1010, 0, 32'h0,        0, 32'h0,  0, 32'h0,        4'b0000, 128'h0);
    vt[5]  = mk(4'b1010, 1, 32'h0,        1, 32'h4,  0, 32'h0,        4'b1000, 128'h0);
    vt[6]  = mk(4'b1010, 0, 32'h12345678, 0, 32'h0,  0, 32'h0,        4'b0000,
                {32'h12345678, 96'h0});
    vt[7]  = mk(4'b1010, 0, 32'h12345678, 0, 32'h0,  0, 32'h0,        4'b0000, 128'h0);
    vt[8]  = mk(4'b1010, 0, 32'h0,        1, 32'h10, 1, 32'hDEADBEEF, 4'b0000, 128'h0);
    vt[9]  = mk(4'b1000, 0, 32'h0,        0, 32'h10, 1, 32'hDEADBEEF, 4'b0000, 128'h0);
    vt[10] = mk(4'b1010, 0, 32'h0,        0, 32'h0,  0, 32'h0,        4'b0000, 128'h0);
    vt[11] = mk(4'b1010, 0, 32'h0,        1, 32'h10, 1, 32'hDEADBEEF, 4'b0000, 128'h0);
    vt[12] = mk(4'b1010, 1, 32'h0,        1, 32'h10, 1, 32'hDEADBEEF, 4'b0010, 128'h0);
    vt[13] = mk(4'b0000, 0, 32'h0,        0, 32'h0,  0, 32'h0,        4'b0000, 128'h0);

    // reset state, with an active request present
    rst_n = 1'b0; s_ack0 = 0; s_ack2 = 0; s_rdata = 32'hFFFF_FFFF;
    m_req = 4'b1111; m_cmd = 4'b0000; m_addr = '0; m_wdata = '1;
    #2;
    check_all_zero("reset");
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    m_req = 4'b0000; s_rdata = 0;
    rst_n = 1'b1;

    // directed table: write from m1, read from m3, abort of m1
    m_addr  = {32'h0000_0004, 32'h0, 32'h0000_0010, 32'h0};
    m_wdata = {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0};
    m_cmd   = 4'b0010;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      m_req = vt[i].req; s_ack0 = vt[i].ack; s_rdata = vt[i].rdata;
      #3;
      chk($sformatf("vec%0d_s_req", i),   s_req0,   vt[i].e_sreq);
      chk($sformatf("vec%0d_s_addr", i),  s_addr0,  vt[i].e_saddr);
      chk($sformatf("vec%0d_s_cmd", i),   s_cmd0,   vt[i].e_scmd);
      chk($sformatf("vec%0d_s_wdata", i), s_wdata0, vt[i].e_swdata);
      chk($sformatf("vec%0d_m_ack", i),   m_ack0,   vt[i].e_mack);
      chk($sformatf("vec%0d_m_rdata", i), m_rdata0, vt[i].e_mrdata);
    end

    // address filter on the SLAVE_ID=2'b10 port
    @(posedge clk); #1; m_req = 0; s_ack0 = 0;
    do_reset();
    m_addr  = {32'h0, 32'h8000_0000, 32'h0, 32'h4000_0000};
    m_wdata = {32'h0, 32'hCAFE_0002, 32'h0, 32'hCAFE_0000};
    m_cmd = 4'b1111; m_req = 4'b0101; s_ack2 = 1;
    n_m2 = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #4;
      chk("filt_m0_ack", m_ack2[0], 0);
      chk("filt_addr_is_m0", (s_req2 && s_addr2 == 32'h4000_0000), 0);
      if (m_ack2[2]) n_m2++;
    end
    chk("filt_m2_grants", n_m2, 4);
    chk("filt_slave0_idle", s_req0, 0);

    // fairness: all four continuously eligible writers
    @(posedge clk); #1; m_req = 0; s_ack2 = 0;
    do_reset();
    m_addr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
    m_cmd = 4'b1111; m_req = 4'b1111; s_ack0 = 1;
    order.delete();
    for (int c = 0; c < 64 && order.size() < 16; c++) begin
      @(posedge clk); #4;
      for (int i = 0; i < 4; i++) if (m_ack0[i]) order.push_back(i);
    end
    chk("fair_count", order.size(), 16);
    for (int i = 0; i < order.size(); i++) chk($sformatf("fair_order%0d", i), order[i], i % 4);

    // reset mid-GRANT, after ptr has advanced
    @(posedge clk); #1; m_req = 0; s_ack0 = 0;
    do_reset();
    m_addr = {32'h0000_0A30, 32'h0, 32'h0000_0A10, 32'h0000_0A00};
    m_req = 4'b0010; s_ack0 = 1;
    @(posedge clk); #1;             // m1 granted and acked this cycle
    @(posedge clk); #1;
    m_req = 4'b1001; s_ack0 = 0;
    @(posedge clk); #1;             // m3 granted (ptr at 2)
    #1;
    chk("rstg_pre_s_req", s_req0, 1);
    chk("rstg_pre_s_addr", s_addr0, 32'h0000_0A30);
    rst_n = 1'b0;
    #1; s_ack0 = 1; #1;
    check_all_zero("rstg");
    @(posedge clk); #1;
    rst_n = 1'b1; s_ack0 = 0;
    @(posedge clk); #2;
    chk("rstg_post_s_req", s_req0, 1);
    chk("rstg_post_s_addr", s_addr0, 32'h0000_0A00);

    // randomized traffic against the model
    @(posedge clk); #1; m_req = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          m_req[i] = ($urandom_range(0, 3) != 0);
          m_cmd[i] = 1'($urandom_range(0, 1));
          m_addr[i*32 +: 32]  = {2'($urandom_range(0, 3)), 30'($urandom)};
          m_wdata[i*32 +: 32] = $urandom;
        end
      end
      s_ack0  = ($urandom_range(0, 2) != 0);
      s_ack2  = ($urandom_range(0, 2) != 0);
      s_rdata = $urandom;
      #3;
      model_check(0);
      model_check(1);
      model_step(0);
      model_step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
